// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Two-byte instruction store with playback. Loads program bytes
//               in IDLE and issues one stored word per cycle in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    output logic          load_ready,
    input  logic          clear,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    output logic [7:0]    inst_hi,
    output logic [7:0]    inst_lo,
    output logic          inst_valid,
    output logic          busy,
    output logic [AW:0]   prog_len,
    output logic          done,
    output logic          err
);

    localparam logic [7:0]  C_NOP_HI  = 8'hF0;
    localparam logic [7:0]  C_NOP_LO  = 8'h00;
    localparam logic [AW:0] C_LEN_MAX = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW:0]    len_q, len_d;
    logic           half_q, half_d;
    logic [7:0]     stage_q, stage_d;
    logic [7:0]     hi_q, hi_d;
    logic [7:0]     lo_q, lo_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           w_mem_we;
    logic           w_last;
    logic [15:0]    mem_q [DEPTH];

    assign load_ready = (state_q == S_IDLE) && (len_q < C_LEN_MAX) && !start && !clear;
    assign w_last     = ({1'b0, pc_q} == (len_q - 1'b1));

    assign inst_hi    = hi_q;
    assign inst_lo    = lo_q;
    assign inst_valid = valid_q;
    assign busy       = busy_q;
    assign prog_len   = len_q;
    assign done       = done_q;
    assign err        = err_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        half_d   = half_q;
        stage_d  = stage_q;
        hi_d     = C_NOP_HI;
        lo_d     = C_NOP_LO;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        w_mem_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    len_d  = '0;
                    half_d = 1'b0;
                end else if (start) begin
                    // A half-loaded instruction or an empty store cannot run
                    if ((len_q == '0) || half_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        pc_d    = '0;
                    end
                end else if (load_valid && load_ready) begin
                    if (!half_q) begin
                        stage_d = load_byte;
                        half_d  = 1'b1;
                    end else begin
                        w_mem_we = 1'b1;
                        len_d    = len_q + 1'b1;
                        half_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end else begin
                    hi_d    = mem_q[pc_q][15:8];
                    lo_d    = mem_q[pc_q][7:0];
                    valid_d = 1'b1;
                    if (w_last) begin
                        pc_d = '0;
                        if (!loop_en) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            half_q  <= 1'b0;
            stage_q <= '0;
            hi_q    <= C_NOP_HI;
            lo_q    <= C_NOP_LO;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            half_q  <= half_d;
            stage_q <= stage_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Store contents survive reset and clear; only prog_len bounds what is played
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[len_q[AW-1:0]] <= {stage_q, load_byte};
        end
    end

endmodule
`default_nettype wire
